trig_coinc_engine: RTL and testbench

//  Parametrised N-channel trigger combiner: stretches per-channel hit inputs, forms a masked

---
 rtl/trig_pkg.sv | 27 ++
 rtl/trig_stretch.sv | 24 ++
 rtl/trig_coinc_engine.sv | 202 ++++++++++++++++++++
 tb/tb_trig_coinc_engine.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared types, default sizes and helpers for the trigger coincidence engine.
package trig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    DEAD = 2'd2
  } trig_state_e;

  localparam int NCH_DEF    = 16;
  localparam int WIN_W_DEF  = 6;
  localparam int DEAD_W_DEF = 8;
  localparam int PW_W_DEF   = 4;
  localparam int CNT_W_DEF  = 32;
  localparam int ROLL_W_DEF = 26;

  // Popcount result width: enough for up to 32 channels.
  localparam int POP_W = 6;

  function automatic logic [POP_W-1:0] popcount(input logic [31:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/trig_stretch.sv
// One hit stretcher: reloads to the window length on a hit, then counts down.
// The channel is active while the counter is non-zero.
module trig_stretch #(
  parameter int WIN_W = 6
) (
  input  logic             clk_adc,
  input  logic             nrst,
  input  logic             i_hit,
  input  logic [WIN_W-1:0] i_window,
  output logic             o_active
);

  logic [WIN_W-1:0] r_str;

  // Reload on hit (a held hit keeps reloading), otherwise decay to zero.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst)             r_str <= '0;
    else if (i_hit)        r_str <= i_window;
    else if (r_str != '0)  r_str <= r_str - WIN_W'(1);
  end

  assign o_active = (r_str != '0);

endmodule

// File: rtl/trig_coinc_engine.sv
// N-channel trigger combiner: stretch, masked multiplicity coincidence,
// random prescale, single trigger pulse with width and deadtime, plus
// saturating monitoring counters.
// Optional feature: define TRIG_ROLLING_EN to build the rolling (periodic)
// trigger timer; without it cfg_roll_en/cfg_roll_period are ignored.
module trig_coinc_engine
  import trig_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int WIN_W  = WIN_W_DEF,
  parameter int DEAD_W = DEAD_W_DEF,
  parameter int PW_W   = PW_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ROLL_W = ROLL_W_DEF,
  localparam int MULT_W = $clog2(NCH + 1),
  localparam int SEL_W  = $clog2(NCH)
) (
  input  logic              clk_adc,
  input  logic              nrst,
  input  logic [NCH-1:0]    hit_in,
  input  logic [NCH-1:0]    cfg_mask,
  input  logic [MULT_W-1:0] cfg_mult,
  input  logic [WIN_W-1:0]  cfg_window,
  input  logic [DEAD_W-1:0] cfg_dead,
  input  logic [PW_W-1:0]   cfg_width,
  input  logic [31:0]       randnum,
  input  logic [31:0]       prescale,
  input  logic              cfg_roll_en,
  input  logic [ROLL_W-1:0] cfg_roll_period,
  input  logic              cnt_clear,
  input  logic [SEL_W-1:0]  cnt_sel,
  output logic              trig_out,
  output logic              trig_busy,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  accept_count,
  output logic [CNT_W-1:0]  reject_count
);

  trig_state_e       r_state, w_next;
  logic [NCH-1:0]    r_hit_q, r_hit_d, w_active, w_rise;
  logic [31:0]       w_masked, r_rand_q, r_pre_q;
  logic [POP_W-1:0]  w_mult_ext;
  logic              r_coinc, r_pass, w_roll_exp;
  logic              w_fire_entry, w_acc_inc, w_rej_inc;
  logic [PW_W-1:0]   r_pw, w_pw_load;
  logic [DEAD_W-1:0] r_dead;
  logic [CNT_W-1:0]  r_acc, r_rej, r_hit_count;
  logic [CNT_W-1:0]  r_hit_cnt [NCH];
  logic [CNT_W-1:0]  w_cnt_pad [2**SEL_W];

  // E1: register raw hits; keep a delayed copy for edge detection.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      r_hit_q <= '0;
      r_hit_d <= '0;
    end else begin
      r_hit_q <= hit_in;
      r_hit_d <= r_hit_q;
    end
  end

  // E2: per-channel stretchers.
  for (genvar g = 0; g < NCH; g++) begin : g_str
    trig_stretch #(.WIN_W(WIN_W)) u_str (
      .clk_adc  (clk_adc),
      .nrst     (nrst),
      .i_hit    (r_hit_q[g]),
      .i_window (cfg_window),
      .o_active (w_active[g])
    );
  end

  assign w_rise     = r_hit_q & ~r_hit_d;
  assign w_masked   = 32'(w_active & cfg_mask);
  assign w_mult_ext = POP_W'(cfg_mult);
  assign w_pw_load  = (cfg_width == '0) ? PW_W'(1) : cfg_width;

  // E3: coincidence decision and prescale pass, aligned to each other.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      r_coinc  <= 1'b0;
      r_pass   <= 1'b0;
      r_rand_q <= '0;
      r_pre_q  <= '0;
    end else begin
      r_coinc  <= (cfg_mult != '0) && (popcount(w_masked) >= w_mult_ext);
      r_rand_q <= randnum;
      r_pre_q  <= prescale;
      r_pass   <= (r_rand_q <= r_pre_q);
    end
  end

`ifdef TRIG_ROLLING_EN
  logic [ROLL_W-1:0] r_roll;

  assign w_roll_exp = cfg_roll_en && (cfg_roll_period != '0) &&
                      (r_roll == cfg_roll_period - ROLL_W'(1));

  // Rolling timer: runs in IDLE while enabled, restarts on every fire.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst)                             r_roll <= '0;
    else if (w_fire_entry)                 r_roll <= '0;
    else if (r_state == IDLE && cfg_roll_en) r_roll <= r_roll + ROLL_W'(1);
  end
`else
  logic w_unused;
  assign w_roll_exp = 1'b0;
  assign w_unused   = ^{cfg_roll_en, cfg_roll_period};
`endif

  // E4: FSM state register.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a coincidence takes priority over roll expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_coinc && r_pass) w_next = FIRE;
        else if (r_coinc)      w_next = DEAD;
        else if (w_roll_exp)   w_next = FIRE;
      end
      FIRE:    if (r_pw <= PW_W'(1)) w_next = DEAD;
      DEAD:    if (r_dead == '0)     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs and counter strobes.
  always_comb begin
    trig_out     = (r_state == FIRE);
    trig_busy    = (r_state != IDLE);
    w_fire_entry = (r_state == IDLE) && (w_next == FIRE);
    w_acc_inc    = (r_state == IDLE) && r_coinc && r_pass;
    w_rej_inc    = (r_state == IDLE) && r_coinc && !r_pass;
  end

  // Pulse-width / deadtime counters and accept/reject monitors.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      r_pw   <= '0;
      r_dead <= '0;
      r_acc  <= '0;
      r_rej  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire_entry)   r_pw   <= w_pw_load;
          else if (w_rej_inc) r_dead <= cfg_dead;
        end
        FIRE: begin
          r_pw <= r_pw - PW_W'(1);
          if (r_pw <= PW_W'(1)) r_dead <= cfg_dead;
        end
        DEAD:    if (r_dead != '0) r_dead <= r_dead - DEAD_W'(1);
        default: ;
      endcase
      if (cnt_clear) begin
        r_acc <= '0;
        r_rej <= '0;
      end else begin
        if (w_acc_inc && r_acc != '1) r_acc <= r_acc + CNT_W'(1);
        if (w_rej_inc && r_rej != '1) r_rej <= r_rej + CNT_W'(1);
      end
    end
  end

  // Saturating per-channel rising-edge counters, independent of the mask.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NCH; i++) r_hit_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cnt_clear)                             r_hit_cnt[i] <= '0;
        else if (w_rise[i] && r_hit_cnt[i] != '1) r_hit_cnt[i] <= r_hit_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Unused select codes read as zero.
  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_pad
    if (g < NCH) begin : g_ch
      assign w_cnt_pad[g] = r_hit_cnt[g];
    end else begin : g_zero
      assign w_cnt_pad[g] = '0;
    end
  end

  // Registered readout mux.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) r_hit_count <= '0;
    else       r_hit_count <= w_cnt_pad[cnt_sel];
  end

  assign hit_count    = r_hit_count;
  assign accept_count = r_acc;
  assign reject_count = r_rej;

endmodule

// File: tb/tb_trig_coinc_engine.sv
// Directed bench for trig_coinc_engine (NCH=12 so cnt_sel can reach NCH).
// Build with or without TRIG_ROLLING_EN; the rolling checks follow the macro.
module tb_trig_coinc_engine;

  localparam int NCH = 12;

  logic        clk = 1'b0;
  logic        nrst;
  logic [11:0] hit_in, cfg_mask;
  logic [3:0]  cfg_mult;
  logic [5:0]  cfg_window;
  logic [7:0]  cfg_dead;
  logic [3:0]  cfg_width;
  logic [31:0] randnum, prescale;
  logic        cfg_roll_en;
  logic [25:0] cfg_roll_period;
  logic        cnt_clear;
  logic [3:0]  cnt_sel;
  logic        trig_out, trig_busy;
  logic [31:0] hit_count, accept_count, reject_count;

  int checks = 0;
  int errors = 0;
  logic tr [0:299];
  logic bz [0:299];
  int n_trig, n_rise, rise1, rise2;

  trig_coinc_engine #(.NCH(NCH)) dut (
    .clk_adc(clk), .nrst(nrst), .hit_in(hit_in), .cfg_mask(cfg_mask),
    .cfg_mult(cfg_mult), .cfg_window(cfg_window), .cfg_dead(cfg_dead),
    .cfg_width(cfg_width), .randnum(randnum), .prescale(prescale),
    .cfg_roll_en(cfg_roll_en), .cfg_roll_period(cfg_roll_period),
    .cnt_clear(cnt_clear), .cnt_sel(cnt_sel), .trig_out(trig_out),
    .trig_busy(trig_busy), .hit_count(hit_count),
    .accept_count(accept_count), .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, optional one-cycle hits at cycles ca/cb, recording outputs.
  task automatic run(input int n, input int ca, input logic [11:0] va,
                     input int cb, input logic [11:0] vb);
    logic prev;
    prev = 1'b0; n_trig = 0; n_rise = 0; rise1 = -1; rise2 = -1;
    for (int c = 0; c < n; c++) begin
      hit_in = (c == ca) ? va : (c == cb) ? vb : 12'h000;
      tr[c] = trig_out;
      bz[c] = trig_busy;
      if (trig_out) n_trig++;
      if (trig_out && !prev) begin
        if (n_rise == 0) rise1 = c;
        else if (n_rise == 1) rise2 = c;
        n_rise++;
      end
      prev = trig_out;
      tick();
    end
    hit_in = '0;
  endtask

  initial begin
    nrst = 1'b0; hit_in = '0; cfg_mask = 12'h001; cfg_mult = 4'd1;
    cfg_window = 6'd5; cfg_dead = 8'd10; cfg_width = 4'd4;
    randnum = 32'd0; prescale = 32'hFFFF_FFFF; cfg_roll_en = 1'b0;
    cfg_roll_period = 26'd100; cnt_clear = 1'b0; cnt_sel = 4'd0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    tick(); tick();

    chk("rst_trig", 64'(trig_out), 64'd0);
    chk("rst_busy", 64'(trig_busy), 64'd0);
    chk("rst_acc", 64'(accept_count), 64'd0);
    chk("rst_rej", 64'(reject_count), 64'd0);
    chk("rst_hitcnt", 64'(hit_count), 64'd0);

    // Single hit, mult=1: pulse cycles 4..7, IDLE at 19.
    run(24, 0, 12'h001, -1, 12'h000);
    chk("t1_trig3", 64'(tr[3]), 64'd0);
    chk("t1_trig4", 64'(tr[4]), 64'd1);
    chk("t1_trig7", 64'(tr[7]), 64'd1);
    chk("t1_trig8", 64'(tr[8]), 64'd0);
    chk("t1_busy18", 64'(bz[18]), 64'd1);
    chk("t1_busy19", 64'(bz[19]), 64'd0);
    chk("t1_acc", 64'(accept_count), 64'd1);

    // Two-fold coincidence: overlap fires, 4-cycle gap does not.
    cfg_mult = 4'd2; cfg_mask = 12'h003; cfg_window = 6'd3;
    cfg_width = 4'd2; cfg_dead = 8'd2;
    run(16, 0, 12'h001, 2, 12'h002);
    chk("t2_fire_cyc6", 64'(tr[6]), 64'd1);
    chk("t2_fire_len", 64'(n_trig), 64'd2);
    run(16, 0, 12'h001, 4, 12'h002);
    chk("t2_nofire", 64'(n_trig), 64'd0);
    chk("t2_acc", 64'(accept_count), 64'd2);

    // Width 0 behaves as 1.
    cfg_mult = 4'd1; cfg_mask = 12'h001; cfg_window = 6'd2;
    cfg_width = 4'd0; cfg_dead = 8'd0;
    run(12, 0, 12'h001, -1, 12'h000);
    chk("t2_w0_len", 64'(n_trig), 64'd1);
    chk("t2_w0_acc", 64'(accept_count), 64'd3);

    // Prescale reject; second coincidence inside DEAD is ignored.
    prescale = 32'd0; randnum = 32'd5; cfg_window = 6'd3; cfg_dead = 8'd20;
    tick(); tick(); tick();
    run(30, 0, 12'h001, 6, 12'h001);
    chk("t3_nopulse", 64'(n_trig), 64'd0);
    chk("t3_rej", 64'(reject_count), 64'd1);
    chk("t3_acc", 64'(accept_count), 64'd3);
    chk("t3_busy4", 64'(bz[4]), 64'd1);
    chk("t3_busy24", 64'(bz[24]), 64'd1);
    chk("t3_busy25", 64'(bz[25]), 64'd0);
    prescale = 32'hFFFF_FFFF; randnum = 32'd0;

    // Hit counters.
    cfg_mult = 4'd0;
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    chk("t5_acc_clr", 64'(accept_count), 64'd0);
    chk("t5_rej_clr", 64'(reject_count), 64'd0);
    cnt_sel = 4'd3;
    for (int i = 0; i < 10; i++) begin
      hit_in = 12'h008; tick();
      hit_in = 12'h000; tick();
    end
    tick(); tick(); tick();
    chk("t5_cnt10", 64'(hit_count), 64'd10);
    cnt_sel = 4'd0; tick();
    chk("t5_ch0", 64'(hit_count), 64'd0);
    cnt_sel = 4'd3; tick();
    chk("t5_cnt10_again", 64'(hit_count), 64'd10);
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0; tick();
    chk("t5_clr", 64'(hit_count), 64'd0);
    hit_in = 12'h008; tick(); hit_in = 12'h000;
    tick(); tick(); tick();
    chk("t5_cnt1", 64'(hit_count), 64'd1);
    // Clear lands on the same edge as an increment: clear wins.
    hit_in = 12'h008; tick();
    hit_in = 12'h000; cnt_clear = 1'b1; tick();
    cnt_clear = 1'b0; tick(); tick(); tick();
    chk("t5_clr_wins", 64'(hit_count), 64'd0);
    cnt_sel = 4'd12; tick(); tick();
    chk("t5_sel_oor", 64'(hit_count), 64'd0);

    // Asynchronous reset in the middle of a pulse.
    cfg_mult = 4'd1; cfg_mask = 12'h001; cfg_window = 6'd2;
    cfg_width = 4'd8; cfg_dead = 8'd4;
    run(6, 0, 12'h001, -1, 12'h000);
    chk("t6_in_fire", 64'(trig_out), 64'd1);
    chk("t6_acc_pre", 64'(accept_count), 64'd1);
    #2 nrst = 1'b0;
    #1;
    chk("t6_trig_async", 64'(trig_out), 64'd0);
    chk("t6_busy_async", 64'(trig_busy), 64'd0);
    chk("t6_acc_async", 64'(accept_count), 64'd0);
    tick();
    nrst = 1'b1;
    tick(); tick();
    chk("t6_idle", 64'(trig_busy), 64'd0);
    chk("t6_trig_after", 64'(trig_out), 64'd0);

    // Rolling trigger, no hits.
    cfg_mult = 4'd0; cfg_width = 4'd4; cfg_dead = 8'd10;
    cfg_roll_period = 26'd100; cfg_roll_en = 1'b1;
    run(240, -1, 12'h000, -1, 12'h000);
`ifdef TRIG_ROLLING_EN
    chk("t4_rise1", 64'(rise1), 64'd100);
    chk("t4_rise2", 64'(rise2), 64'd215);
    chk("t4_len", 64'(n_trig), 64'd8);
`else
    chk("t4_nopulse", 64'(n_trig), 64'd0);
`endif
    chk("t4_acc", 64'(accept_count), 64'd0);
    chk("t4_rej", 64'(reject_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
